text_message_ctrl: RTL and testbench

//  Sequences on-screen text messages for the letter bitmap renderer.
//  - Maps the current VGA pixel to a character cell, letter code and in-cell offset.
//  - Runs a per-frame reveal/blink state machine that decides which letters are visible.
//  - Sits between the VGA sync/pixel counters and the letter bitmap; its registered

---
 rtl/text_pkg.sv | 42 ++++
 rtl/text_msg_rom.sv | 20 ++
 rtl/text_message_ctrl.sv | 133 +++++++++++++
 tb/tb_text_message_ctrl.sv | 220 ++++++++++++++++++++++
 4 files changed

// File: rtl/text_pkg.sv
// Shared constants for the on-screen text sequencer: letter codes,
// message tables and the reveal/blink state encoding.
package text_pkg;

  typedef logic [5:0] letter_t;

  localparam letter_t L_BLANK = 6'd0;
  localparam letter_t L_P     = 6'd1;
  localparam letter_t L_R     = 6'd2;
  localparam letter_t L_E     = 6'd3;
  localparam letter_t L_S     = 6'd4;
  localparam letter_t L_A     = 6'd5;
  localparam letter_t L_C     = 6'd6;
  localparam letter_t L_T     = 6'd7;
  localparam letter_t L_O     = 6'd8;
  localparam letter_t L_N     = 6'd9;
  localparam letter_t L_D     = 6'd10;
  localparam letter_t L_M     = 6'd11;
  localparam letter_t L_I     = 6'd12;
  localparam letter_t L_Z     = 6'd13;
  localparam letter_t L_B     = 6'd14;
  localparam letter_t L_K     = 6'd15;
  localparam letter_t L_Y     = 6'd16;
  localparam letter_t L_U     = 6'd17;
  localparam letter_t L_W     = 6'd18;
  localparam letter_t L_L     = 6'd19;

  localparam logic [3:0] MAX_LEN = 4'd12;

  // Message lengths: PRESS START, PAUSED, YOU WIN, YOU LOST
  localparam logic [3:0] MSG_LEN [4] = '{4'd11, 4'd6, 4'd7, 4'd8};

  localparam letter_t MSG_TABLE [4][MAX_LEN] = '{
    '{L_P, L_R, L_E, L_S, L_S, L_BLANK, L_S, L_T, L_A, L_R, L_T, L_BLANK},
    '{L_P, L_A, L_U, L_S, L_E, L_D, L_BLANK, L_BLANK, L_BLANK, L_BLANK, L_BLANK, L_BLANK},
    '{L_Y, L_O, L_U, L_BLANK, L_W, L_I, L_N, L_BLANK, L_BLANK, L_BLANK, L_BLANK, L_BLANK},
    '{L_Y, L_O, L_U, L_BLANK, L_L, L_O, L_S, L_T, L_BLANK, L_BLANK, L_BLANK, L_BLANK}
  };

  typedef enum logic [1:0] {IDLE, REVEAL, HOLD} state_t;

endpackage

// File: rtl/text_msg_rom.sv
// Combinational message store: (message, character index) -> letter code
// plus the message length. Swapping message sets only touches this file
// and the package tables.
module text_msg_rom
  import text_pkg::*;
(
  input  logic [1:0] msg,
  input  logic [3:0] char_idx,
  output letter_t    code,
  output logic [3:0] len
);

  // Table lookup; indices past the table end read as blank
  always_comb begin
    code = L_BLANK;
    if (char_idx < MAX_LEN) code = MSG_TABLE[msg][char_idx];
    len = MSG_LEN[msg];
  end

endmodule

// File: rtl/text_message_ctrl.sv
// Text message sequencer: maps the current pixel to a character cell and
// runs the per-frame reveal/blink state machine feeding the letter bitmap.
module text_message_ctrl
  import text_pkg::*;
#(
  parameter logic [10:0] TOP_LEFT_X    = 11'd256,
  parameter logic [10:0] TOP_LEFT_Y    = 11'd200,
  parameter int unsigned SCALE_LOG2    = 0,
  parameter logic [7:0]  REVEAL_FRAMES = 8'd6,
  parameter logic [7:0]  BLINK_ON      = 8'd30,
  parameter logic [7:0]  BLINK_OFF     = 8'd20
) (
  input  logic        clk,
  input  logic        resetN,
  input  logic [10:0] pixelX,
  input  logic [10:0] pixelY,
  input  logic        startOfFrame,
  input  logic        show,
  input  logic [1:0]  msgSel,
  output logic [5:0]  letter,
  output logic [10:0] offsetX,
  output logic [10:0] offsetY,
  output logic        InsideRectangle,
  output logic        textDone
);

  state_t      state_q, state_d;
  logic [1:0]  msg_q, msg_d;
  logic [3:0]  reveal_q, reveal_d;
  logic [7:0]  frame_q, frame_d;
  logic [7:0]  blink_q, blink_d;
  logic        restart;

  logic [3:0]  len;
  letter_t     rom_code;
  logic [8:0]  blink_period;
  logic [10:0] dx, dy, char_idx, off_x, off_y, box_w, box_h;
  logic        in_box, active, visible;

  assign blink_period = {1'b0, BLINK_ON} + {1'b0, BLINK_OFF};

  // Message latch: entering from IDLE or a selection change restarts the reveal
  always_comb begin
    restart = show && (state_q == IDLE || msgSel != msg_q);
    msg_d   = restart ? msgSel : msg_q;
  end

  text_msg_rom u_rom (
    .msg      (msg_d),
    .char_idx (char_idx[3:0]),
    .code     (rom_code),
    .len      (len)
  );

  // Next-state: show=0 beats a restart, both beat the frame tick
  always_comb begin
    state_d  = state_q;
    reveal_d = reveal_q;
    frame_d  = frame_q;
    blink_d  = blink_q;
    if (!show) begin
      state_d  = IDLE;
      reveal_d = '0;
      frame_d  = '0;
      blink_d  = '0;
    end else if (restart) begin
      state_d  = REVEAL;
      reveal_d = '0;
      frame_d  = '0;
      blink_d  = '0;
    end else if (startOfFrame) begin
      case (state_q)
        REVEAL: begin
          if (frame_q >= REVEAL_FRAMES - 8'd1) begin
            frame_d  = '0;
            reveal_d = reveal_q + 4'd1;
            if (reveal_q + 4'd1 >= len) state_d = HOLD;
          end else begin
            frame_d = frame_q + 8'd1;
          end
        end
        HOLD: begin
          if ({1'b0, blink_q} + 9'd1 >= blink_period) blink_d = '0;
          else                                        blink_d = blink_q + 8'd1;
        end
        default: ;
      endcase
    end
  end

  // Pixel geometry; outputs are derived from the post-edge state so that
  // an abort or restart is reflected on the very next clock
  always_comb begin
    dx       = pixelX - TOP_LEFT_X;
    dy       = pixelY - TOP_LEFT_Y;
    char_idx = dx >> (3 + SCALE_LOG2);
    off_x    = (dx >> SCALE_LOG2) & 11'd7;
    off_y    = (dy >> SCALE_LOG2) & 11'd15;
    box_w    = {7'd0, len} << (3 + SCALE_LOG2);
    box_h    = 11'd16 << SCALE_LOG2;
    in_box   = (dx < box_w) && (dy < box_h);
    active   = (state_d != IDLE);
    visible  = (state_d == REVEAL) || (state_d == HOLD && blink_d < BLINK_ON);
  end

  // State, counters and registered bitmap-facing outputs
  always_ff @(posedge clk or posedge resetN) begin
    if (resetN) begin
      state_q         <= IDLE;
      msg_q           <= '0;
      reveal_q        <= '0;
      frame_q         <= '0;
      blink_q         <= '0;
      letter          <= '0;
      offsetX         <= '0;
      offsetY         <= '0;
      InsideRectangle <= 1'b0;
      textDone        <= 1'b0;
    end else begin
      state_q         <= state_d;
      msg_q           <= msg_d;
      reveal_q        <= reveal_d;
      frame_q         <= frame_d;
      blink_q         <= blink_d;
      letter          <= (active && in_box) ? rom_code : L_BLANK;
      offsetX         <= active ? off_x : '0;
      offsetY         <= active ? off_y : '0;
      InsideRectangle <= active && visible && in_box && (char_idx < {7'd0, reveal_d});
      textDone        <= (state_d == HOLD);
    end
  end

endmodule

// File: tb/tb_text_message_ctrl.sv
// Self-checking bench for text_message_ctrl: two instances (1x with blink,
// 2x without blink) compared every cycle against a frame-count model.
module tb_text_message_ctrl;

  localparam int RF        = 6;
  localparam int ON        = 30;
  localparam int FRAME_CYC = 12;

  logic        clk = 1'b0;
  logic        resetN = 1'b1;
  logic [10:0] pixelX = '0, pixelY = '0;
  logic        startOfFrame = 1'b0, show = 1'b0;
  logic [1:0]  msgSel = '0;

  logic [5:0]  letter_a, letter_b;
  logic [10:0] ox_a, oy_a, ox_b, oy_b;
  logic        in_a, in_b, done_a, done_b;

  int n_vec = 0;
  int n_err = 0;

  // model state: message active, latched message, frames since (re)start
  int    active = 0;
  int    m = 0;
  int    frames = 0;
  string msgs[4];

  always #5 clk = ~clk;

  text_message_ctrl #(
    .TOP_LEFT_X(11'd256), .TOP_LEFT_Y(11'd200), .SCALE_LOG2(0),
    .REVEAL_FRAMES(8'd6), .BLINK_ON(8'd30), .BLINK_OFF(8'd20)
  ) u_dut_a (
    .clk(clk), .resetN(resetN), .pixelX(pixelX), .pixelY(pixelY),
    .startOfFrame(startOfFrame), .show(show), .msgSel(msgSel),
    .letter(letter_a), .offsetX(ox_a), .offsetY(oy_a),
    .InsideRectangle(in_a), .textDone(done_a)
  );

  text_message_ctrl #(
    .TOP_LEFT_X(11'd256), .TOP_LEFT_Y(11'd200), .SCALE_LOG2(1),
    .REVEAL_FRAMES(8'd6), .BLINK_ON(8'd30), .BLINK_OFF(8'd0)
  ) u_dut_b (
    .clk(clk), .resetN(resetN), .pixelX(pixelX), .pixelY(pixelY),
    .startOfFrame(startOfFrame), .show(show), .msgSel(msgSel),
    .letter(letter_b), .offsetX(ox_b), .offsetY(oy_b),
    .InsideRectangle(in_b), .textDone(done_b)
  );

  task automatic check_val(input string tag, input int got, input int exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic int code_of(input byte c);
    case (c)
      "P": return 1;  "R": return 2;  "E": return 3;  "S": return 4;
      "A": return 5;  "C": return 6;  "T": return 7;  "O": return 8;
      "N": return 9;  "D": return 10; "M": return 11; "I": return 12;
      "Z": return 13; "B": return 14; "K": return 15; "Y": return 16;
      "U": return 17; "W": return 18; "L": return 19;
      default: return 0;
    endcase
  endfunction

  // Expected outputs for a given magnification / blink-off setting
  task automatic model_out(input int s, input int boff, input logic [10:0] px, input logic [10:0] py,
                           output int e_let, output int e_ox, output int e_oy,
                           output int e_in, output int e_done);
    int  len, dx, dy, ci, reveal, hf;
    bit  box, vis;
    len    = msgs[m].len();
    dx     = (int'(px) - 256) & 'h7ff;
    dy     = (int'(py) - 200) & 'h7ff;
    ci     = dx >> (3 + s);
    box    = (dx < (len << (3 + s))) && (dy < (16 << s));
    reveal = frames / RF;
    if (reveal > len) reveal = len;
    hf     = frames - len * RF;
    vis    = (hf < 0) || (boff == 0) || ((hf % (ON + boff)) < ON);
    e_done = (active != 0 && hf >= 0) ? 1 : 0;
    e_in   = (active != 0 && vis && box && ci < reveal) ? 1 : 0;
    e_let  = 0;
    if (active != 0 && box) e_let = code_of(msgs[m][ci]);
    e_ox   = (active != 0) ? ((dx >> s) & 7) : 0;
    e_oy   = (active != 0) ? ((dy >> s) & 15) : 0;
  endtask

  // One clock: drive at negedge, advance the model, compare after posedge
  task automatic tick(input bit rst, input bit sof, input logic [10:0] px, input logic [10:0] py);
    int el, ex, ey, ei, ed;
    @(negedge clk);
    resetN = rst; startOfFrame = sof; pixelX = px; pixelY = py;
    if (rst)                                   begin active = 0; frames = 0; m = 0; end
    else if (!show)                            active = 0;
    else if (active == 0 || int'(msgSel) != m) begin active = 1; m = int'(msgSel); frames = 0; end
    else if (sof)                              frames++;
    @(posedge clk);
    #1;
    model_out(0, 20, px, py, el, ex, ey, ei, ed);
    check_val("a.letter", int'(letter_a), el);
    check_val("a.offsetX", int'(ox_a), ex);
    check_val("a.offsetY", int'(oy_a), ey);
    check_val("a.inside", int'(in_a), ei);
    check_val("a.textDone", int'(done_a), ed);
    model_out(1, 0, px, py, el, ex, ey, ei, ed);
    check_val("b.letter", int'(letter_b), el);
    check_val("b.offsetX", int'(ox_b), ex);
    check_val("b.offsetY", int'(oy_b), ey);
    check_val("b.inside", int'(in_b), ei);
    check_val("b.textDone", int'(done_b), ed);
  endtask

  function automatic logic [10:0] rnd_x();
    if ($urandom_range(0, 9) == 0) return 11'($urandom);
    return 11'(230 + $urandom_range(0, 240));
  endfunction

  function automatic logic [10:0] rnd_y();
    if ($urandom_range(0, 9) == 0) return 11'($urandom);
    return 11'(190 + $urandom_range(0, 50));
  endfunction

  task automatic run_frames(input int n);
    for (int f = 0; f < n; f++)
      for (int c = 0; c < FRAME_CYC; c++)
        tick(1'b0, c == 0, rnd_x(), rnd_y());
  endtask

  initial begin
    msgs[0] = "PRESS START";
    msgs[1] = "PAUSED";
    msgs[2] = "YOU WIN";
    msgs[3] = "YOU LOST";

    // reset, then a 3-clock reset pulse in the middle of an idle frame
    show = 1'b0; msgSel = 2'd0;
    tick(1'b1, 1'b0, 11'd300, 11'd205);
    tick(1'b1, 1'b0, 11'd300, 11'd205);
    for (int c = 0; c < 5; c++) tick(1'b0, c == 0, rnd_x(), rnd_y());
    for (int c = 0; c < 3; c++) tick(1'b1, 1'b0, rnd_x(), rnd_y());
    run_frames(2);
    check_val("idle.letter", int'(letter_a), 0);

    // reveal of PRESS START
    show = 1'b1;
    tick(1'b0, 1'b0, rnd_x(), rnd_y());
    run_frames(6);
    tick(1'b0, 1'b0, 11'd259, 11'd205);
    check_val("reveal.cell0.inside", int'(in_a), 1);
    check_val("reveal.cell0.letter", int'(letter_a), 1);
    tick(1'b0, 1'b0, 11'd267, 11'd205);
    check_val("reveal.cell1.inside", int'(in_a), 0);
    check_val("reveal.cell1.letter", int'(letter_a), 2);
    tick(1'b0, 1'b0, 11'd293, 11'd209);
    check_val("map.letter", int'(letter_b), 3);
    check_val("map.offsetX", int'(ox_b), 2);
    check_val("map.offsetY", int'(oy_b), 4);
    run_frames(60);
    tick(1'b0, 1'b0, rnd_x(), rnd_y());
    check_val("reveal.done66", int'(done_a), 1);

    // blink: hidden after 30 hold frames, back after 50; no blink on b
    run_frames(30);
    tick(1'b0, 1'b0, 11'd259, 11'd205);
    check_val("blink.off.a", int'(in_a), 0);
    check_val("blink.off.letter", int'(letter_a), 1);
    check_val("blink.none.b", int'(in_b), 1);
    run_frames(20);
    tick(1'b0, 1'b0, 11'd259, 11'd205);
    check_val("blink.on.a", int'(in_a), 1);

    // abort mid-reveal on a frame pulse, then restart from zero
    show = 1'b0; tick(1'b0, 1'b0, rnd_x(), rnd_y());
    show = 1'b1; tick(1'b0, 1'b0, rnd_x(), rnd_y());
    run_frames(20);
    show = 1'b0;
    tick(1'b0, 1'b1, 11'd259, 11'd205);
    check_val("abort.inside", int'(in_a), 0);
    show = 1'b1;
    tick(1'b0, 1'b0, 11'd259, 11'd205);
    check_val("restart.inside", int'(in_a), 0);
    run_frames(6);
    tick(1'b0, 1'b0, 11'd259, 11'd205);
    check_val("restart.cell0", int'(in_a), 1);

    // message switch in HOLD
    run_frames(60);
    tick(1'b0, 1'b0, rnd_x(), rnd_y());
    check_val("switch.pre.done", int'(done_a), 1);
    msgSel = 2'd2;
    tick(1'b0, 1'b0, rnd_x(), rnd_y());
    check_val("switch.done", int'(done_a), 0);
    run_frames(6);
    tick(1'b0, 1'b0, 11'd259, 11'd205);
    check_val("switch.cell0.letter", int'(letter_a), 16);
    check_val("switch.cell0.inside", int'(in_a), 1);
    run_frames(36);
    tick(1'b0, 1'b0, 11'd313, 11'd205);
    check_val("switch.cell7.letter", int'(letter_a), 0);
    check_val("switch.cell7.inside", int'(in_a), 0);
    tick(1'b0, 1'b0, 11'd338, 11'd205);
    check_val("switch.cell10.inside", int'(in_a), 0);

    // randomized traffic
    for (int i = 0; i < 3000; i++) begin
      if (show && $urandom_range(0, 199) == 0) show = 1'b0;
      else if (!show && $urandom_range(0, 19) == 0) show = 1'b1;
      if ($urandom_range(0, 399) == 0) msgSel = 2'($urandom);
      tick($urandom_range(0, 999) == 0, $urandom_range(0, 3) == 0, rnd_x(), rnd_y());
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
